instr_encoder: RTL



---
 rtl/instr_pkg.sv | 71 +++++++
 rtl/instr_encoder_sync_fifo.sv | 53 +++++
 rtl/instr_encoder.sv | 130 +++++++++++++
 3 files changed

// File: rtl/instr_pkg.sv
// Shared RV32I encoding constants, request kinds and encoder helpers for the
// program loader; the control decoder imports the same opcode constants.
package instr_pkg;

    typedef enum logic [2:0] {
        KIND_ADDI = 3'd0,
        KIND_LW   = 3'd1,
        KIND_ADD  = 3'd2,
        KIND_BEQ  = 3'd3,
        KIND_BNE  = 3'd4
    } kind_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WRITE,
        ST_FULL
    } enc_state_e;

    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_ADDI = 3'b000;
    localparam logic [2:0] F3_LW   = 3'b010;
    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [6:0] F7_ADD  = 7'b0000000;

    localparam logic [31:0] NOP_WORD = 32'h0000_0013;

    function automatic logic [31:0] encode(
        input logic [2:0]  kind,
        input logic [4:0]  rd,
        input logic [4:0]  rs1,
        input logic [4:0]  rs2,
        input logic [12:0] imm
    );
        logic [31:0] word;
        word = NOP_WORD;
        case (kind)
            KIND_ADDI: word = {imm[11:0], rs1, F3_ADDI, rd, OP_IMM};
            KIND_LW:   word = {imm[11:0], rs1, F3_LW, rd, OP_LOAD};
            KIND_ADD:  word = {F7_ADD, rs2, rs1, F3_ADD, rd, OP_REG};
            KIND_BEQ:  word = {imm[12], imm[10:5], rs2, rs1, F3_BEQ,
                               imm[4:1], imm[11], OP_BRANCH};
            KIND_BNE:  word = {imm[12], imm[10:5], rs2, rs1, F3_BNE,
                               imm[4:1], imm[11], OP_BRANCH};
            default:   word = NOP_WORD;
        endcase
        return word;
    endfunction

    // A 13-bit immediate fits the 12-bit I-type field when its top two bits agree.
    function automatic logic request_ok(
        input logic [2:0]  kind,
        input logic [12:0] imm
    );
        logic ok;
        ok = 1'b1;
        case (kind)
            KIND_ADDI, KIND_LW: ok = (imm[12] == imm[11]);
            KIND_ADD:           ok = 1'b1;
            KIND_BEQ, KIND_BNE: ok = !imm[0];
            default:            ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/instr_encoder_sync_fifo.sv
// Synchronous FIFO with full/empty/count flags; clear empties it in one cycle.
// Read data is the head entry, valid whenever empty is low.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] storage [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of the order the always blocks evaluate.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // NOTE: storage is deliberately not reset; the pointers define which
    // entries are valid, and an unreset array maps cleanly onto RAM/LUT cells.
    always_ff @(posedge clk) begin
        if (do_push) storage[wr_ptr[AW-1:0]] <= wdata;
    end

    assign rdata = storage[rd_ptr[AW-1:0]];
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count = wr_ptr - rd_ptr;

endmodule

// File: rtl/instr_encoder.sv
// Program loader: encodes symbolic requests into RV32I words, buffers them and
// streams them to instruction memory. Define ENCODE_CHECK_EN to drop bad requests.
module instr_encoder
    import instr_pkg::*;
#(
    parameter int                    FIFO_DEPTH = 4,
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
    parameter int                    MEM_WORDS  = 256
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          flush,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [2:0]                    in_kind,
    input  logic [4:0]                    in_rd,
    input  logic [4:0]                    in_rs1,
    input  logic [4:0]                    in_rs2,
    input  logic [12:0]                   in_imm,
    output logic                          mem_we,
    output logic [ADDR_WIDTH-1:0]         mem_addr,
    output logic [31:0]                   mem_wdata,
    output logic                          mem_full,
    output logic [$clog2(MEM_WORDS):0]    words_written,
    output logic                          err
);

    localparam int WW = $clog2(MEM_WORDS) + 1;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    enc_state_e            state;
    enc_state_e            state_next;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [CW-1:0]         fifo_count;
    logic [31:0]           fifo_rdata;
    logic [31:0]           enc_word;
    logic                  accept;
    logic                  req_ok;
    logic                  push;
    logic                  pop;
    logic                  last_word;
    logic [ADDR_WIDTH-1:0] wr_ptr;

    assign mem_full  = (state == ST_FULL);
    assign in_ready  = !fifo_full && !mem_full && !flush;
    assign accept    = in_valid && in_ready;
    assign enc_word  = encode(in_kind, in_rd, in_rs1, in_rs2, in_imm);
    assign push      = accept && req_ok;
    assign pop       = (state == ST_WRITE) && !flush;
    assign last_word = (words_written == WW'(MEM_WORDS - 1));

`ifdef ENCODE_CHECK_EN
    assign req_ok = request_ok(in_kind, in_imm);

    always_ff @(posedge clk) begin
        if (rst)                   err <= 1'b0;
        else if (accept && !req_ok) err <= 1'b1;
    end
`else
    assign req_ok = 1'b1;
    assign err    = 1'b0;
`endif

    sync_fifo #(
        .WIDTH (32),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .clear (flush),
        .push  (push),
        .wdata (enc_word),
        .pop   (pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    // NOTE: state_next gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        if (flush) begin
            state_next = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:  if (push) state_next = ST_WRITE;
                ST_WRITE: begin
                    if (pop && last_word)
                        state_next = ST_FULL;
                    else if (fifo_count == CW'(1) && !push)
                        state_next = ST_IDLE;
                end
                ST_FULL:  state_next = ST_FULL;
                default:  state_next = ST_IDLE;
            endcase
        end
    end

    // fifo_empty is implied by ST_IDLE; kept visible for debug of the pointer logic.
    logic unused_fifo_empty;
    assign unused_fifo_empty = fifo_empty;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            mem_we        <= 1'b0;
            mem_addr      <= BASE_ADDR;
            mem_wdata     <= '0;
            wr_ptr        <= BASE_ADDR;
            words_written <= '0;
        end else begin
            mem_we <= pop;
            if (pop) begin
                mem_addr      <= wr_ptr;
                mem_wdata     <= fifo_rdata;
                wr_ptr        <= wr_ptr + ADDR_WIDTH'(4);
                words_written <= words_written + WW'(1);
            end
        end
    end

endmodule
